// File: rtl/spi_input_sync.sv
// rtl/spi_input_sync.sv - two-flop synchronizer plus edge-detect flop for one asynchronous input
module spi_input_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Reset value is chosen per input so a line already active at reset release yields one edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/spi_slave_driver.sv
// rtl/spi_slave_driver.sv - SPI mode-0 slave, MSB first, with back-to-back word streaming
module spi_slave_driver #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  ready,
    output logic                  prepare,
    input  logic                  mosi,
    output logic                  miso,
    input  logic                  sclk,
    input  logic                  cs
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    logic w_cs_rise;
    logic w_cs_fall;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_mosi;

    state_t                r_state;
    state_t                w_state_next;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_rx;
    logic [DATA_WIDTH-1:0] r_tx;
    logic                  r_any_word;
    logic                  r_done;
    logic                  r_ready;
    logic                  w_reload;

    spi_input_sync #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .i_async(cs),
        .o_level(), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spi_input_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .i_async(sclk),
        .o_level(), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_input_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .i_async(mosi),
        .o_level(w_mosi), .o_rise(), .o_fall()
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A cs edge always wins over a coincident sclk edge
    always_comb begin
        w_state_next = r_state;
        w_reload     = 1'b0;
        prepare      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_next = ST_ACTIVE;
                    prepare      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_next = ST_IDLE;
                end else if (w_sclk_fall && r_cnt == '0 && r_any_word) begin
                    w_reload = 1'b1;
                    prepare  = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Counter parks at DATA_WIDTH for one cycle so data_out loads one cycle after the last shift
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_rx       <= '0;
            r_tx       <= '0;
            r_any_word <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b0;
            data_out   <= '0;
        end else begin
            r_done  <= 1'b0;
            r_ready <= r_done;
            if (r_state == ST_IDLE) begin
                if (w_cs_fall) begin
                    r_tx       <= data_in;
                    r_cnt      <= '0;
                    r_any_word <= 1'b0;
                end
            end else if (w_cs_rise) begin
                r_cnt      <= '0;
                r_any_word <= 1'b0;
            end else begin
                if (r_cnt == CNT_FULL) begin
                    r_cnt      <= '0;
                    data_out   <= r_rx;
                    r_done     <= 1'b1;
                    r_any_word <= 1'b1;
                end else if (w_sclk_rise) begin
                    r_rx  <= {r_rx[DATA_WIDTH-2:0], w_mosi};
                    r_cnt <= r_cnt + CW'(1);
                end
                if (w_reload) begin
                    r_tx <= data_in;
                end else if (w_sclk_fall) begin
                    r_tx <= {r_tx[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    assign ready = r_ready;
    assign miso  = (r_state == ST_ACTIVE) & r_tx[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_slave_driver.sv
// tb/tb_spi_slave_driver.sv - scoreboard bench for spi_slave_driver in 8-bit and 16-bit builds
module tb_spi_slave_driver;

    logic        clk;
    logic        rst;
    logic        cs8;
    logic        cs16;
    logic        sclk;
    logic        mosi;
    logic [7:0]  data_in8;
    logic [15:0] data_in16;
    logic [7:0]  data_out8;
    logic [15:0] data_out16;
    logic        ready8;
    logic        ready16;
    logic        prepare8;
    logic        prepare16;
    logic        miso8;
    logic        miso16;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;
    int prep8  = 0;
    int prep16 = 0;

    logic [15:0] exp8_d[$];
    int          exp8_c[$];
    logic [15:0] exp16_d[$];
    int          exp16_c[$];
    logic [7:0]  feed8[$];

    spi_slave_driver #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .data_in(data_in8), .data_out(data_out8),
        .ready(ready8), .prepare(prepare8), .mosi(mosi), .miso(miso8),
        .sclk(sclk), .cs(cs8)
    );

    spi_slave_driver #(.DATA_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .data_in(data_in16), .data_out(data_out16),
        .ready(ready16), .prepare(prepare16), .mosi(mosi), .miso(miso16),
        .sclk(sclk), .cs(cs16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor: pops expected word and ready cycle on each ready pulse
    initial forever begin
        @(negedge clk);
        if (ready8) begin
            if (exp8_d.size() == 0) check("ready8_unexpected", 32'd1, 32'd0);
            else begin
                check("ready8_data", data_out8, exp8_d.pop_front());
                check("ready8_latency", cyc, exp8_c.pop_front());
            end
        end
        if (ready16) begin
            if (exp16_d.size() == 0) check("ready16_unexpected", 32'd1, 32'd0);
            else begin
                check("ready16_data", data_out16, exp16_d.pop_front());
                check("ready16_latency", cyc, exp16_c.pop_front());
            end
        end
        if (ready8 && prepare8) check("ready8_prepare_overlap", 32'd1, 32'd0);
        if (ready16 && prepare16) check("ready16_prepare_overlap", 32'd1, 32'd0);
    end

    initial forever begin
        @(negedge clk);
        if (prepare8) begin
            prep8++;
            @(posedge clk);
            #1;
            if (feed8.size() > 0) data_in8 = feed8.pop_front();
        end
    end

    initial forever begin
        @(negedge clk);
        if (prepare16) prep16++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Mode-0 master: 4 clk per sclk half period, samples miso just before each rising edge
    task automatic xfer(input bit s16, input int nbits, input logic [15:0] word,
                        input bit end_low, output logic [15:0] got);
        got = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = word[i];
            repeat (4) @(posedge clk);
            #2;
            got  = {got[14:0], (s16 ? miso16 : miso8)};
            sclk = 1'b1;
            if (i == 0 && nbits == (s16 ? 16 : 8)) begin
                if (s16) begin
                    exp16_d.push_back(word);
                    exp16_c.push_back(cyc + 1 + 4);
                end else begin
                    exp8_d.push_back(word);
                    exp8_c.push_back(cyc + 1 + 4);
                end
            end
            if (i > 0 || end_low) begin
                repeat (4) @(posedge clk);
                #2;
                sclk = 1'b0;
            end
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic finish_high(input bit s16);
        wait_clk(4);
        if (s16) cs16 = 1'b1;
        else cs8 = 1'b1;
        wait_clk(4);
        sclk = 1'b0;
        wait_clk(8);
    endtask

    logic [15:0] got;

    initial begin
        rst = 1'b0; cs8 = 1'b0; cs16 = 1'b0; sclk = 1'b0; mosi = 1'b0;
        data_in8 = '0; data_in16 = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2 sclk = ~sclk;
            @(negedge clk);
            check("reset_outputs",
                  {data_out8, ready8, prepare8, miso8, data_out16, ready16, prepare16, miso16}, 32'd0);
        end
        @(posedge clk);
        #2 cs8 = 1'b1; cs16 = 1'b1; sclk = 1'b0;
        wait_clk(1);
        rst = 1'b1;
        wait_clk(4);
        check("reset_prepare_count", prep8 + prep16, 0);

        data_in8 = 8'hA5;
        cs8 = 1'b0;
        wait_clk(8);
        xfer(1'b0, 8, 16'h003C, 1'b0, got);
        check("single_miso", got[7:0], 8'hA5);
        finish_high(1'b0);
        check("single_data_out", data_out8, 8'h3C);
        check("single_prepare_count", prep8, 1);

        cs8 = 1'b0;
        wait_clk(8);
        xfer(1'b0, 5, 16'h001F, 1'b1, got);
        cs8 = 1'b1;
        wait_clk(12);
        check("abort_data_out", data_out8, 8'h3C);
        check("abort_prepare_count", prep8, 2);

        cs8 = 1'b0;
        wait_clk(8);
        xfer(1'b0, 8, 16'h0081, 1'b0, got);
        finish_high(1'b0);
        check("after_abort_data_out", data_out8, 8'h81);

        data_in8 = 8'h01;
        feed8.push_back(8'h02);
        feed8.push_back(8'h00);
        cs8 = 1'b0;
        wait_clk(8);
        xfer(1'b0, 8, 16'h00F0, 1'b1, got);
        check("burst_miso_0", got[7:0], 8'h01);
        xfer(1'b0, 8, 16'h000F, 1'b1, got);
        check("burst_miso_1", got[7:0], 8'h02);
        wait_clk(4);
        cs8 = 1'b1;
        wait_clk(8);
        check("burst_prepare_count", prep8, 6);
        check("burst_data_out", data_out8, 8'h0F);

        for (int i = 0; i < 20; i++) begin
            wait_clk(4);
            sclk = ~sclk;
            @(negedge clk);
            check("idle_miso", {miso8, miso16}, 2'b00);
        end
        wait_clk(8);
        check("idle_prepare_count", prep8 + prep16, 6);

        data_in16 = 16'h1234;
        cs16 = 1'b0;
        wait_clk(8);
        xfer(1'b1, 16, 16'hBEEF, 1'b0, got);
        check("w16_miso", got, 16'h1234);
        finish_high(1'b1);
        check("w16_data_out", data_out16, 16'hBEEF);
        check("w16_prepare_count", prep16, 1);

        wait_clk(20);
        check("ready8_missing", exp8_d.size(), 0);
        check("ready16_missing", exp16_d.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
